// File: rtl/z88_pkg.sv
// Shared constants and FSM state type for the Z88 slot memory controller.
package z88_pkg;

  localparam int unsigned NSLOTS_DEF = 5;
  localparam int unsigned AW_DEF     = 19;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned WSW_DEF    = 3;

  localparam int unsigned SLOT_ROM0  = 0;
  localparam int unsigned SLOT_RAM0  = 1;
  localparam int unsigned SLOT_CARD1 = 2;
  localparam int unsigned SLOT_CARD2 = 3;
  localparam int unsigned SLOT_CARD3 = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE
  } state_t;

endpackage

// File: rtl/z88_slot_sel.sv
// Lowest-index priority encoder over active-low slot selects, with multi-select detect.
module z88_slot_sel
  import z88_pkg::*;
#(
  parameter int unsigned NSLOTS = NSLOTS_DEF,
  parameter int unsigned SW     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1
) (
  input  logic [NSLOTS-1:0] cs_n,
  output logic [SW-1:0]     slot,
  output logic              any,
  output logic              multi
);

  logic [NSLOTS-1:0] sel;

  always_comb begin
    sel  = ~cs_n;
    slot = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (sel[i]) slot = SW'(i);
    end
    any   = |sel;
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi = |(sel & (sel - NSLOTS'(1)));
  end

endmodule

// File: rtl/z88_slot_ctrl.sv
// Multi-slot async memory controller with per-slot programmable wait states.
// Optional write protection enabled by defining Z88_SLOT_WRPROT_EN.
module z88_slot_ctrl
  import z88_pkg::*;
#(
  parameter int unsigned NSLOTS = NSLOTS_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned WSW    = WSW_DEF,
  parameter logic [NSLOTS*WSW-1:0] WS_INIT = {NSLOTS{WSW'(1)}}
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NSLOTS-1:0]                           req_cs_n,
  input  logic [AW-1:0]                               req_a,
  input  logic                                        req_rd,
  input  logic                                        req_wr,
  input  logic [DW-1:0]                               req_wdata,
  output logic [DW-1:0]                               rdata,
  output logic                                        wait_n,
  output logic [AW-1:0]                               mem_a,
  output logic [DW-1:0]                               mem_wdata,
  input  logic [DW-1:0]                               mem_rdata,
  output logic [NSLOTS-1:0]                           mem_ce_n,
  output logic                                        mem_oe_n,
  output logic                                        mem_we_n,
  input  logic                                        cfg_we,
  input  logic [((NSLOTS > 1) ? $clog2(NSLOTS) : 1)-1:0] cfg_slot,
  input  logic [WSW-1:0]                              cfg_ws,
`ifdef Z88_SLOT_WRPROT_EN
  input  logic [NSLOTS-1:0]                           cfg_wp,
  output logic                                        wp_hit,
`endif
  output logic                                        err
);

  localparam int unsigned SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  state_t                       state, state_nxt;
  logic [SW-1:0]                sel_slot, slot_q;
  logic                         sel_any, sel_multi;
  logic                         valid_c, load_c, capture_c, wp_blk;
  logic                         wr_q;
  logic [WSW-1:0]               cnt;
  logic [NSLOTS-1:0][WSW-1:0]   ws_tab;
  logic [NSLOTS-1:0]            ce_n_d;
  logic                         oe_n_d, we_n_d;

  function automatic logic [NSLOTS-1:0] ce_vec(input logic [SW-1:0] s);
    ce_vec = ~(NSLOTS'(1) << s);
  endfunction

  z88_slot_sel #(.NSLOTS(NSLOTS), .SW(SW)) u_sel (
    .cs_n  (req_cs_n),
    .slot  (sel_slot),
    .any   (sel_any),
    .multi (sel_multi)
  );

  assign valid_c = (req_rd | req_wr) & sel_any;
  assign wait_n  = reset | ~(((state == IDLE) && valid_c) || (state == SETUP) || (state == STROBE));

  // Next state and next values of the registered memory strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    capture_c = 1'b0;
    ce_n_d    = '1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    case (state)
      IDLE: begin
        if (valid_c) begin
          state_nxt = SETUP;
          load_c    = 1'b1;
          ce_n_d    = ce_vec(sel_slot);
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        ce_n_d    = ce_vec(slot_q);
        oe_n_d    = wr_q;
        we_n_d    = ~wr_q | wp_blk;
      end
      STROBE: begin
        ce_n_d = ce_vec(slot_q);
        if (cnt == '0) begin
          state_nxt = HOLD;
          capture_c = ~wr_q;
        end else begin
          oe_n_d = wr_q;
          we_n_d = ~wr_q | wp_blk;
        end
      end
      HOLD:    state_nxt = RELEASE;
      RELEASE: if (!valid_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_ce_n  <= '1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_a     <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      slot_q    <= '0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      ws_tab    <= WS_INIT;
    end else begin
      state    <= state_nxt;
      mem_ce_n <= ce_n_d;
      mem_oe_n <= oe_n_d;
      mem_we_n <= we_n_d;
      if (load_c) begin
        slot_q    <= sel_slot;
        wr_q      <= req_wr & ~req_rd;
        mem_a     <= req_a;
        mem_wdata <= req_wdata;
        cnt       <= ws_tab[sel_slot];
        if (sel_multi || (req_rd && req_wr)) err <= 1'b1;
      end else if ((state == STROBE) && (cnt != '0)) begin
        cnt <= cnt - WSW'(1);
      end
      if (capture_c) rdata <= mem_rdata;
      // Table read above sees the pre-update value, so an access latched this edge keeps its old count.
      if (cfg_we && (32'(cfg_slot) < NSLOTS)) ws_tab[cfg_slot] <= cfg_ws;
    end
  end

`ifdef Z88_SLOT_WRPROT_EN
  logic [NSLOTS-1:0] wp_tab;
  logic              wp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_tab <= '0;
      wp_q   <= 1'b0;
      wp_hit <= 1'b0;
    end else begin
      if (cfg_we && (32'(cfg_slot) < NSLOTS)) wp_tab[cfg_slot] <= cfg_wp[cfg_slot];
      if (load_c) begin
        wp_q <= req_wr & ~req_rd & wp_tab[sel_slot];
        if (req_wr && !req_rd && wp_tab[sel_slot]) wp_hit <= 1'b1;
      end
    end
  end

  assign wp_blk = wp_q;
`else
  assign wp_blk = 1'b0;
`endif

endmodule
